// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP) with a memory-ready handshake and timeout trap.
// Optional performance counters are enabled by defining MULTICYCLE_CTRL_PERF_EN.
module multicycle_controller #(
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         instr_opcode,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               ir_write,
    output logic               pc_write,
    output logic               alu_src,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               branch,
    output logic               auipc,
    output logic               trap,
    output logic [1:0]         trap_cause,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   instret_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    logic [2:0]        state_q, state_d;
    logic [6:0]        opcode_q, opcode_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]        cause_q, cause_d;
    logic [2:0]        alu_op3_s;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_LW, OP_SW, OP_I, OP_BR,
            OP_JAL, OP_JALR, OP_AUIPC, OP_LUI: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_class(input logic [6:0] op);
        case (op)
            OP_R:     return 3'b000;
            OP_I:     return 3'b010;
            OP_LW:    return 3'b011;
            OP_SW:    return 3'b001;
            OP_BR:    return 3'b100;
            OP_JAL:   return 3'b000;
            OP_JALR:  return 3'b010;
            OP_AUIPC: return 3'b101;
            OP_LUI:   return 3'b110;
            default:  return 3'b000;
        endcase
    endfunction

    function automatic logic uses_imm(input logic [6:0] op);
        case (op)
            OP_LW, OP_SW, OP_I, OP_JALR, OP_AUIPC, OP_LUI: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

    function automatic logic is_flow(input logic [6:0] op);
        case (op)
            OP_BR, OP_JAL, OP_JALR: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    // Next-state, opcode capture, wait counter and trap cause
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        wait_d   = wait_q;
        cause_d  = cause_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                wait_d  = '0;
            end
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                opcode_d = instr_opcode;
                if (is_legal(instr_opcode)) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            S_EXEC: begin
                case (opcode_q)
                    OP_LW, OP_SW: begin
                        state_d = S_MEM;
                        wait_d  = '0;
                    end
                    OP_BR: begin
                        state_d = S_FETCH;
                        wait_d  = '0;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                // A ready in the final allowed cycle still completes the access
                if (mem_ready) begin
                    if (opcode_q == OP_SW) begin
                        state_d = S_FETCH;
                        wait_d  = '0;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                wait_d  = '0;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state and bookkeeping registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            opcode_q <= 7'd0;
            wait_q   <= '0;
            cause_q  <= 2'b00;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            wait_q   <= wait_d;
            cause_q  <= cause_d;
        end
    end

    // Control outputs from state and latched opcode; FETCH strobes follow mem_ready
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_op3_s  = 3'b000;
        branch     = 1'b0;
        auipc      = 1'b0;
        trap       = 1'b0;
        trap_cause = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end else begin
                    ir_write = 1'b0;
                    pc_write = 1'b0;
                end
            end
            S_EXEC: begin
                alu_op3_s = alu_class(opcode_q);
                alu_src   = uses_imm(opcode_q);
                auipc     = (opcode_q == OP_AUIPC);
                if (is_flow(opcode_q)) begin
                    branch   = 1'b1;
                    pc_write = 1'b1;
                end else begin
                    branch   = 1'b0;
                    pc_write = 1'b0;
                end
            end
            S_MEM: begin
                mem_req   = 1'b1;
                alu_src   = 1'b1;
                alu_op3_s = alu_class(opcode_q);
                mem_we    = (opcode_q == OP_SW);
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (opcode_q == OP_LW);
                alu_op3_s  = alu_class(opcode_q);
                alu_src    = uses_imm(opcode_q);
                auipc      = (opcode_q == OP_AUIPC);
            end
            S_TRAP: begin
                trap       = 1'b1;
                trap_cause = cause_q;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    // Widen the 3-bit ALU class; upper bits stay zero
    always_comb begin
        alu_op         = '0;
        alu_op[2:0]    = alu_op3_s;
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic             retire_s;
    logic [CNT_W-1:0] cycle_cnt_q, instret_cnt_q;

    assign retire_s = (state_d == S_FETCH) &&
                      ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB));

    // Free-running cycle and retired-instruction counters, wrapping naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 1'b1;
            if (retire_s) begin
                instret_cnt_q <= instret_cnt_q + 1'b1;
            end else begin
                instret_cnt_q <= instret_cnt_q;
            end
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule
